// File: rtl/axis_gen_pkg.sv
// rtl/axis_gen_pkg.sv - shared encodings for the AXI-Stream pattern generator
package axis_gen_pkg;

  localparam logic [1:0] MODE_CNT   = 2'd0;
  localparam logic [1:0] MODE_LFSR  = 2'd1;
  localparam logic [1:0] MODE_WALK  = 2'd2;
  localparam logic [1:0] MODE_CONST = 2'd3;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_GEN  = 1'b1
  } gen_state_t;

endpackage

// File: rtl/axis_sync_fifo.sv
// rtl/axis_sync_fifo.sv - single-clock FWFT FIFO with occupancy output
// The head word is visible the cycle after it is written; output is zero while empty.
module axis_sync_fifo #(
  parameter int WIDTH      = 33,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_valid,
  input  logic [WIDTH-1:0]      wr_data,
  output logic                  rd_valid,
  output logic [WIDTH-1:0]      rd_data,
  input  logic                  rd_ready,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   level
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  do_wr;
  logic                  do_rd;

  assign full     = (count == (ADDR_WIDTH+1)'(DEPTH));
  assign rd_valid = (count != '0);
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;
  assign level    = count;

  // A read frees a slot in the same cycle, so a full FIFO can still take a write.
  assign do_wr = wr_valid && (!full || rd_ready);
  assign do_rd = rd_valid && rd_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (do_rd) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (ADDR_WIDTH+1)'(1);
        2'b01:   count <= count - (ADDR_WIDTH+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/axis_pattern_gen_fifo.sv
// rtl/axis_pattern_gen_fifo.sv - AXI-Stream traffic source: pattern generator into an FWFT FIFO
// Packets are framed by tlast; configuration is latched only when leaving IDLE.
module axis_pattern_gen_fifo
  import axis_gen_pkg::*;
#(
  parameter int                    DATA_SIZE  = 32,
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    LEN_WIDTH  = 16,
  parameter logic [DATA_SIZE-1:0]  LFSR_TAPS  = 32'h80200003
) (
  input  logic                     m00_axis_aclk,
  input  logic                     m00_axis_areset,
  input  logic                     m00_axis_enable,
  input  logic [1:0]               mode,
  input  logic [DATA_SIZE-1:0]     seed,
  input  logic [LEN_WIDTH-1:0]     pkt_len,
  output logic [DATA_SIZE-1:0]     m00_axis_tdata,
  output logic [DATA_SIZE/8-1:0]   m00_axis_tstrb,
  output logic                     m00_axis_tvalid,
  output logic                     m00_axis_tlast,
  input  logic                     m00_axis_tready,
  output logic [ADDR_WIDTH:0]      fifo_level,
  output logic [LEN_WIDTH-1:0]     pkt_count
);

  gen_state_t             state;
  logic [DATA_SIZE-1:0]   pattern;
  logic [LEN_WIDTH-1:0]   beat_cnt;
  logic [LEN_WIDTH-1:0]   eff_len;
  logic [1:0]             cur_mode;
  logic                   fifo_full;
  logic                   wr_en;
  logic                   beat_last;
  logic [DATA_SIZE:0]     rd_word;

  function automatic logic [DATA_SIZE-1:0] next_pattern(input logic [1:0] m,
                                                        input logic [DATA_SIZE-1:0] p);
    case (m)
      MODE_CNT:  return p + DATA_SIZE'(1);
      MODE_LFSR: return {p[DATA_SIZE-2:0], ^(p & LFSR_TAPS)};
      MODE_WALK: return {p[DATA_SIZE-2:0], p[DATA_SIZE-1]};
      default:   return p;
    endcase
  endfunction

  assign wr_en     = (state == S_GEN) && !fifo_full;
  assign beat_last = (beat_cnt == eff_len - LEN_WIDTH'(1));

  always_ff @(posedge m00_axis_aclk) begin
    if (m00_axis_areset) begin
      state    <= S_IDLE;
      pattern  <= seed;
      beat_cnt <= '0;
      eff_len  <= LEN_WIDTH'(1);
      cur_mode <= MODE_CNT;
    end else begin
      case (state)
        S_IDLE: begin
          if (m00_axis_enable && !fifo_full) begin
            cur_mode <= mode;
            eff_len  <= (pkt_len == '0) ? LEN_WIDTH'(1) : pkt_len;
            // An all-zero LFSR would lock up, so it starts from 1 instead.
            pattern  <= (mode == MODE_LFSR && seed == '0) ? DATA_SIZE'(1) : seed;
            beat_cnt <= '0;
            state    <= S_GEN;
          end
        end
        S_GEN: begin
          if (!fifo_full) begin
            pattern <= next_pattern(cur_mode, pattern);
            if (beat_last) begin
              beat_cnt <= '0;
              if (!m00_axis_enable) state <= S_IDLE;
            end else begin
              beat_cnt <= beat_cnt + LEN_WIDTH'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  axis_sync_fifo #(
    .WIDTH      (DATA_SIZE + 1),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fifo (
    .clk      (m00_axis_aclk),
    .reset    (m00_axis_areset),
    .wr_valid (wr_en),
    .wr_data  ({beat_last, pattern}),
    .rd_valid (m00_axis_tvalid),
    .rd_data  (rd_word),
    .rd_ready (m00_axis_tready),
    .full     (fifo_full),
    .level    (fifo_level)
  );

  assign m00_axis_tdata = rd_word[DATA_SIZE-1:0];
  assign m00_axis_tlast = rd_word[DATA_SIZE];
  assign m00_axis_tstrb = '1;

  always_ff @(posedge m00_axis_aclk) begin
    if (m00_axis_areset) begin
      pkt_count <= '0;
    end else if (m00_axis_tvalid && m00_axis_tready && m00_axis_tlast) begin
      pkt_count <= pkt_count + LEN_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_axis_pattern_gen_fifo.sv
// tb/tb_axis_pattern_gen_fifo.sv - self-checking bench for axis_pattern_gen_fifo
module tb_axis_pattern_gen_fifo;
  import axis_gen_pkg::*;

  localparam logic [31:0] TAPS = 32'h80200003;

  logic        clk = 1'b0;
  logic        rst, en, ready;
  logic [1:0]  mode;
  logic [31:0] seed;
  logic [15:0] len;
  logic [31:0] tdata;
  logic [3:0]  tstrb;
  logic        tvalid, tlast;
  logic [4:0]  level;
  logic [15:0] pkt_count;

  int total = 0;
  int bad   = 0;

  logic [31:0] rx_d[$];
  logic        rx_l[$];
  logic [15:0] model_pkts = '0;
  bit          mon_on = 1'b0;
  bit          stall_prev = 1'b0;
  logic [32:0] held = '0;

  typedef struct {
    logic [1:0]       m;
    logic [31:0]      s;
    logic [15:0]      l;
    logic [3:0][31:0] d;
    logic [3:0]       last;
  } vec_t;
  vec_t tbl[6];

  always #5 clk = ~clk;

  axis_pattern_gen_fifo dut (
    .m00_axis_aclk   (clk),
    .m00_axis_areset (rst),
    .m00_axis_enable (en),
    .mode            (mode),
    .seed            (seed),
    .pkt_len         (len),
    .m00_axis_tdata  (tdata),
    .m00_axis_tstrb  (tstrb),
    .m00_axis_tvalid (tvalid),
    .m00_axis_tlast  (tlast),
    .m00_axis_tready (ready),
    .fifo_level      (level),
    .pkt_count       (pkt_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Beat i of a run, straight from the pattern definitions.
  function automatic logic [31:0] ref_pat(input logic [1:0] m, input logic [31:0] s, input int i);
    logic [31:0] v;
    int k;
    case (m)
      MODE_CNT: return s + 32'(i);
      MODE_WALK: begin
        k = i % 32;
        return (k == 0) ? s : ((s << k) | (s >> (32 - k)));
      end
      MODE_LFSR: begin
        v = (s == 0) ? 32'd1 : s;
        for (int j = 0; j < i; j++) v = {v[30:0], 1'($countones(v & TAPS) % 2)};
        return v;
      end
      default: return s;
    endcase
  endfunction

  always @(negedge clk) begin
    if (mon_on) begin
      chk("pkt_count", pkt_count, model_pkts);
      if (stall_prev) chk("stall_hold", {tvalid, tlast, tdata}, {1'b1, held});
      if (rst) begin
        model_pkts = '0;
        stall_prev = 1'b0;
      end else begin
        if (tvalid && ready) begin
          rx_d.push_back(tdata);
          rx_l.push_back(tlast);
          model_pkts += 16'(tlast);
        end
        stall_prev = tvalid && !ready;
        held = {tlast, tdata};
      end
    end
  end

  task automatic start(input logic [1:0] m, input logic [31:0] s, input logic [15:0] l);
    mode = m; seed = s; len = l;
    rx_d.delete(); rx_l.delete();
    en = 1'b1;
  endtask

  task automatic wait_beats(input int n, input bit rnd);
    for (int c = 0; c < 3000 && rx_d.size() < n; c++) begin
      @(posedge clk); #1;
      if (rnd) ready = 1'($urandom_range(0, 1));
    end
    if (rx_d.size() < n) chk("wait_beats_timeout", rx_d.size(), n);
  endtask

  task automatic drain();
    int quiet = 0;
    en = 1'b0;
    ready = 1'b1;
    for (int c = 0; c < 2000 && quiet < 12; c++) begin
      @(posedge clk); #1;
      quiet = tvalid ? 0 : quiet + 1;
    end
    if (quiet < 12) chk("drain_timeout", quiet, 12);
    chk("drain_level", level, 0);
    chk("drain_pkts", pkt_count, model_pkts);
  endtask

  task automatic check_run(input logic [1:0] m, input logic [31:0] s, input logic [15:0] l);
    int eff = (l == 0) ? 1 : int'(l);
    chk("run_nonempty", rx_d.size() > 0, 1);
    chk("run_whole_packets", rx_d.size() % eff, 0);
    for (int i = 0; i < rx_d.size(); i++)
      chk("run_beat", {rx_l[i], rx_d[i]}, {((i % eff) == eff - 1), ref_pat(m, s, i)});
  endtask

  initial begin
    logic [15:0] base;
    logic [1:0]  rm;
    logic [31:0] rs;
    logic [15:0] rl;

    tbl[0] = '{MODE_CNT,   32'h0,        16'd4, {32'd3, 32'd2, 32'd1, 32'd0}, 4'b1000};
    tbl[1] = '{MODE_WALK,  32'h1,        16'd2, {32'd8, 32'd4, 32'd2, 32'd1}, 4'b1010};
    tbl[2] = '{MODE_CONST, 32'hA5A5A5A5, 16'd0, {4{32'hA5A5A5A5}},            4'b1111};
    tbl[3] = '{MODE_LFSR,  32'h0,        16'd3, {32'hD, 32'h6, 32'h3, 32'h1}, 4'b0100};
    tbl[4] = '{MODE_CNT,   32'hFFFFFFFE, 16'd3, {32'h1, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFE}, 4'b0100};
    tbl[5] = '{MODE_WALK,  32'h80000000, 16'd1, {32'h4, 32'h2, 32'h1, 32'h80000000}, 4'b1111};

    rst = 1'b1; en = 1'b0; ready = 1'b0; mode = MODE_CNT; seed = '0; len = 16'd4;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_level", level, 0);
    chk("rst_pkt_count", pkt_count, 0);
    chk("rst_tstrb", tstrb, 4'hF);
    rst = 1'b0;
    mon_on = 1'b1;

    for (int k = 0; k < 6; k++) begin
      start(tbl[k].m, tbl[k].s, tbl[k].l);
      ready = 1'b1;
      wait_beats(4, 1'b0);
      drain();
      for (int i = 0; i < 4; i++)
        if (i < rx_d.size())
          chk("tbl_beat", {rx_l[i], rx_d[i]}, {tbl[k].last[i], tbl[k].d[i]});
      check_run(tbl[k].m, tbl[k].s, tbl[k].l);
    end

    // Two packets of four accepted -> pkt_count advances by exactly 2.
    base = model_pkts;
    start(MODE_CNT, 32'h0, 16'd4);
    ready = 1'b1;
    wait_beats(8, 1'b0);
    chk("t1_pkt_count", pkt_count, base + 16'd2);
    drain();
    check_run(MODE_CNT, 32'h0, 16'd4);

    // Backpressure: FIFO fills, generator stalls, sequence stays contiguous.
    start(MODE_CNT, 32'h0, 16'd4);
    ready = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("t2_level_full", level, 16);
    chk("t2_tvalid", tvalid, 1);
    chk("t2_head", tdata, 0);
    ready = 1'b1;
    wait_beats(40, 1'b0);
    drain();
    check_run(MODE_CNT, 32'h0, 16'd4);

    // Enable dropped mid-packet: packet still completes, nothing follows.
    start(MODE_CNT, 32'h0, 16'd8);
    ready = 1'b1;
    wait_beats(3, 1'b0);
    en = 1'b0;
    drain();
    chk("t3_beats", rx_d.size(), 8);
    check_run(MODE_CNT, 32'h0, 16'd8);

    // Reset mid-packet with words queued.
    start(MODE_CNT, 32'd100, 16'd8);
    ready = 1'b1;
    wait_beats(20, 1'b0);
    ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_pre_tvalid", tvalid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t5_tvalid", tvalid, 0);
    chk("t5_level", level, 0);
    chk("t5_pkt_count", pkt_count, 0);
    rst = 1'b0;
    rx_d.delete(); rx_l.delete();
    ready = 1'b1;
    wait_beats(10, 1'b0);
    drain();
    check_run(MODE_CNT, 32'd100, 16'd8);

    // Random runs; config inputs are scrambled once a run is going.
    for (int it = 0; it < 8; it++) begin
      rm = 2'($urandom_range(0, 3));
      rs = (it == 2) ? 32'h0 : 32'($urandom);
      rl = 16'($urandom_range(0, 5));
      if (it == 2) rm = MODE_LFSR;
      start(rm, rs, rl);
      ready = 1'($urandom_range(0, 1));
      wait_beats(1, 1'b1);
      mode = 2'($urandom_range(0, 3));
      seed = 32'($urandom);
      len  = 16'($urandom_range(0, 9));
      wait_beats(int'($urandom_range(5, 40)), 1'b1);
      drain();
      check_run(rm, rs, rl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
